serial_rx_fifo: RTL



---
 rtl/serial_rx_pkg.sv | 19 +
 rtl/sync_fifo.sv | 92 +++++++++
 rtl/serial_rx_fifo.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the 8N1 console receive path.
package serial_rx_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_START  = 7;

    function automatic int baud_div(input int clock, input int baud);
        return clock / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with a registered fall-through head; a pop in the same
// cycle frees the slot for a push even when full.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   rd_en,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   valid,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   COUNT_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0]   COUNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   COUNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [AW-1:0]         rd_ptr_nxt_s;
    logic [AW:0]           count_nxt_s;
    logic [DATA_WIDTH-1:0] head_s;
    logic                  push_s;
    logic                  pop_s;

    // Accept/pop decisions and the next head value, bypassing a same-cycle write.
    always_comb begin
        pop_s        = 1'b0;
        push_s       = 1'b0;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count;
        head_s       = {DATA_WIDTH{1'b0}};

        pop_s  = rd_en && (count != COUNT_ZERO);
        push_s = wr_en && ((count != COUNT_FULL) || pop_s);

        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count + COUNT_ONE;
            2'b01:   count_nxt_s = count - COUNT_ONE;
            default: count_nxt_s = count;
        endcase

        if (count_nxt_s == COUNT_ZERO) begin
            head_s = {DATA_WIDTH{1'b0}};
        end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_s = wr_data;
        end else begin
            head_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Pointer, occupancy and head registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count    <= COUNT_ZERO;
            rd_data  <= {DATA_WIDTH{1'b0}};
            valid    <= 1'b0;
            full     <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            rd_ptr_r <= rd_ptr_nxt_s;
            count    <= count_nxt_s;
            rd_data  <= head_s;
            valid    <= (count_nxt_s != COUNT_ZERO);
            full     <= (count_nxt_s == COUNT_FULL);
        end
    end

    // Storage array; contents need no reset since the head is gated by occupancy.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

endmodule

// File: rtl/serial_rx_fifo.sv
// 8N1 receiver with 16x oversampling feeding a byte FIFO, with sticky
// framing and overrun flags for the console character sink.
module serial_rx_fifo
    import serial_rx_pkg::*;
#(
    parameter int CLOCK      = 50000000,
    parameter int BAUD       = 19200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rx,
    input  logic                        rd_en,
    input  logic                        clr_err,
    output logic [7:0]                  data_out,
    output logic                        data_valid,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overrun,
    output logic                        frame_err,
    output logic                        busy
);
    localparam int DIV = baud_div(CLOCK, BAUD);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [3:0]    TC_MID   = 4'(MID_START);
    localparam logic [3:0]    TC_LAST  = 4'(OVERSAMPLE - 1);

    rx_state_t     state_r;
    logic          rx_meta_r;
    logic          rxs_r;
    logic [DW-1:0] div_cnt_r;
    logic          tick_s;
    logic          enter_start_s;
    logic [3:0]    tc_r;
    logic [2:0]    bi_r;
    logic [7:0]    shift_r;
    logic          push_r;
    logic [7:0]    push_data_r;
    logic          stop_bad_r;
    logic          fifo_full_s;
    logic          drop_s;

    // Strobes derived from the divider, the FSM and the FIFO state.
    always_comb begin
        tick_s        = 1'b0;
        enter_start_s = 1'b0;
        drop_s        = 1'b0;
        tick_s        = (div_cnt_r == DIV_LAST);
        enter_start_s = (state_r == IDLE) && !rxs_r;
        drop_s        = push_r && fifo_full_s && !rd_en;
    end

    // Two-flop synchroniser for the asynchronous line; idles high.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_r <= 1'b1;
            rxs_r     <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rxs_r     <= rx_meta_r;
        end
    end

    // Free-running oversample divider, realigned to the start-bit edge.
    always_ff @(posedge clk) begin
        if (reset || enter_start_s || tick_s) begin
            div_cnt_r <= {DW{1'b0}};
        end else begin
            div_cnt_r <= div_cnt_r + DW'(1);
        end
    end

    // Receiver FSM; the assembled byte is handed to the FIFO one clk after the stop sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            tc_r        <= 4'd0;
            bi_r        <= 3'd0;
            shift_r     <= 8'd0;
            push_r      <= 1'b0;
            push_data_r <= 8'd0;
            stop_bad_r  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            push_r     <= 1'b0;
            stop_bad_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (!rxs_r) begin
                        state_r <= START;
                        tc_r    <= 4'd0;
                        busy    <= 1'b1;
                    end
                end
                START: begin
                    if (tick_s) begin
                        if (tc_r == TC_MID) begin
                            if (!rxs_r) begin
                                state_r <= DATA;
                                tc_r    <= 4'd0;
                                bi_r    <= 3'd0;
                            end else begin
                                state_r <= IDLE;
                                busy    <= 1'b0;
                            end
                        end else begin
                            tc_r <= tc_r + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick_s) begin
                        tc_r <= tc_r + 4'd1;
                        if (tc_r == TC_LAST) begin
                            shift_r <= {rxs_r, shift_r[7:1]};
                            bi_r    <= bi_r + 3'd1;
                            if (bi_r == 3'd7) begin
                                state_r <= STOP;
                            end
                        end
                    end
                end
                STOP: begin
                    if (tick_s) begin
                        tc_r <= tc_r + 4'd1;
                        if (tc_r == TC_LAST) begin
                            if (rxs_r) begin
                                push_r      <= 1'b1;
                                push_data_r <= shift_r;
                                state_r     <= IDLE;
                                busy        <= 1'b0;
                            end else begin
                                stop_bad_r <= 1'b1;
                                state_r    <= WAIT_IDLE;
                            end
                        end
                    end
                end
                WAIT_IDLE: begin
                    // A held break stays here, so it reports a single framing error.
                    if (tick_s && rxs_r) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error flags; a new event in the clearing cycle wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (drop_s) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
            if (stop_bad_r) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .DATA_WIDTH (8),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push_r),
        .wr_data (push_data_r),
        .rd_en   (rd_en),
        .rd_data (data_out),
        .valid   (data_valid),
        .full    (fifo_full_s),
        .count   (fifo_count)
    );

endmodule
